bcd_updown_n: RTL and testbench

BCD_UPDOWN_N -- requirements
Module: bcd_updown_n

---
 rtl/bcd_updown_n.sv | 104 ++++++++++
 tb/tb_bcd_updown_n.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_updown_n.sv
// Packed-BCD up/down counter running 0..limit with validated parallel load,
// one-cycle wrap/error pulses and a direction-dependent terminal flag.
module bcd_digit (
  input  logic [3:0] d,
  input  logic       ci,
  input  logic       bi,
  output logic [3:0] inc,
  output logic [3:0] dec
);
  always_comb begin
    inc = d;
    dec = d;
    if (ci) inc = (d == 4'd9) ? 4'd0 : d + 4'd1;
    if (bi) dec = (d == 4'd0) ? 4'd9 : d - 4'd1;
  end
endmodule

module bcd_updown_n #(
  parameter int DIGITS = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  control,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic [4*DIGITS-1:0]   limit,
  output logic [4*DIGITS-1:0]   count,
  output logic                  wrap,
  output logic                  terminal,
  output logic                  error
);
  localparam int W = 4*DIGITS;

  function automatic logic bcd_ok(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  logic [DIGITS-1:0] cy, bw;
  logic [W-1:0]      inc_v, dec_v;
  logic              lim_ok, ld_ok;

  // Carry (borrow) into digit i is set when every lower digit sits at 9 (0).
  assign cy[0] = 1'b1;
  assign bw[0] = 1'b1;
  for (genvar i = 1; i < DIGITS; i++) begin : g_chain
    assign cy[i] = cy[i-1] & (count[4*(i-1) +: 4] == 4'd9);
    assign bw[i] = bw[i-1] & (count[4*(i-1) +: 4] == 4'd0);
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bcd_digit u_dig (
      .d   (count[4*i +: 4]),
      .ci  (cy[i]),
      .bi  (bw[i]),
      .inc (inc_v[4*i +: 4]),
      .dec (dec_v[4*i +: 4])
    );
  end

  assign lim_ok   = bcd_ok(limit);
  assign ld_ok    = bcd_ok(load_value) && (load_value <= limit);
  assign terminal = control ? (count == limit) : (count == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
      wrap  <= 1'b0;
      error <= 1'b0;
    end else begin
      wrap  <= 1'b0;
      error <= 1'b0;
      if (load) begin
        if (ld_ok) count <= load_value;
        else       error <= 1'b1;
      end else if (enable) begin
        if (!lim_ok) begin
          error <= 1'b1;
        end else if (control) begin
          if (count >= limit) begin
            count <= '0;
            wrap  <= 1'b1;
          end else begin
            count <= inc_v;
          end
        end else begin
          if (count == '0) begin
            count <= limit;
            wrap  <= 1'b1;
          end else if (count > limit) begin
            // limit was lowered below the count: clamp without a wrap pulse
            count <= limit;
          end else begin
            count <= dec_v;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_bcd_updown_n.sv
// Directed bench for bcd_updown_n (DIGITS=2 and DIGITS=4 instances) with a short random BCD-legality sweep.
module tb_bcd_updown_n;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        en, ctl, ld;
  logic [7:0]  lv, lim, cnt;
  logic        wr, term, er;
  logic        en4, ctl4, ld4;
  logic [15:0] lv4, lim4, cnt4;
  logic        wr4, term4, er4;

  int n_assert = 0;
  int n_fail   = 0;

  bcd_updown_n #(.DIGITS(2)) u2 (
    .clock(clock), .reset(reset), .enable(en), .control(ctl), .load(ld),
    .load_value(lv), .limit(lim), .count(cnt), .wrap(wr), .terminal(term), .error(er)
  );

  bcd_updown_n #(.DIGITS(4)) u4 (
    .clock(clock), .reset(reset), .enable(en4), .control(ctl4), .load(ld4),
    .load_value(lv4), .limit(lim4), .count(cnt4), .wrap(wr4), .terminal(term4), .error(er4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] bcd2(input int v);
    logic [3:0] t, o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  function automatic logic all_bcd(input logic [15:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++)
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  initial begin
    reset = 1'b1; en = 1'b1; ctl = 1'b0; ld = 1'b1; lv = 8'h42; lim = 8'h59;
    en4 = 1'b0; ctl4 = 1'b1; ld4 = 1'b0; lv4 = 16'h0; lim4 = 16'h9999;

    // reset overrides load and enable
    step();
    chk("rst_count", cnt, 8'h00);
    chk("rst_wrap", wr, 1'b0);
    chk("rst_error", er, 1'b0);
    chk("rst_term_down", term, 1'b1);
    ctl = 1'b1; #1;
    chk("rst_term_up", term, 1'b0);

    // up run 00..59 -> 00
    reset = 1'b0; ld = 1'b0; en = 1'b1; ctl = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      step();
      chk("up_count", cnt, bcd2(i % 60));
      chk("up_wrap", wr, (i == 60));
    end

    // down run from reset: 59 (wrap), 58 ... 00
    reset = 1'b1; ctl = 1'b0;
    step();
    chk("rst2_count", cnt, 8'h00);
    reset = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      step();
      chk("dn_count", cnt, bcd2((60 - k) % 60));
      chk("dn_wrap", wr, (k == 1));
    end

    // load checks
    en = 1'b0; ctl = 1'b1; ld = 1'b1; lv = 8'h5A;
    step();
    chk("ld_bad_digit_count", cnt, 8'h00);
    chk("ld_bad_digit_err", er, 1'b1);
    ld = 1'b0;
    step();
    chk("err_one_cycle", er, 1'b0);
    ld = 1'b1; lv = 8'h70;
    step();
    chk("ld_over_limit_count", cnt, 8'h00);
    chk("ld_over_limit_err", er, 1'b1);
    lv = 8'h42;
    step();
    chk("ld_ok_count", cnt, 8'h42);
    chk("ld_ok_err", er, 1'b0);
    chk("ld_ok_wrap", wr, 1'b0);

    // limit lowered below count
    lv = 8'h45;
    step();
    chk("ld45", cnt, 8'h45);
    ld = 1'b0; lim = 8'h30; en = 1'b1; ctl = 1'b1;
    step();
    chk("lowlim_up_count", cnt, 8'h00);
    chk("lowlim_up_wrap", wr, 1'b1);
    en = 1'b0; ld = 1'b1; lv = 8'h45; lim = 8'h59;
    step();
    chk("ld45b", cnt, 8'h45);
    ld = 1'b0; lim = 8'h30; en = 1'b1; ctl = 1'b0;
    step();
    chk("lowlim_dn_count", cnt, 8'h30);
    chk("lowlim_dn_wrap", wr, 1'b0);
    step();
    chk("dn_borrow", cnt, 8'h29);

    // invalid limit holds with error each cycle
    lim = 8'h3F;
    step();
    chk("badlim_count", cnt, 8'h29);
    chk("badlim_err", er, 1'b1);
    step();
    chk("badlim_count2", cnt, 8'h29);
    chk("badlim_err2", er, 1'b1);

    // limit zero: pinned at 0, wrap every enabled cycle
    lim = 8'h00; ctl = 1'b1;
    step();
    chk("lim0_up_count", cnt, 8'h00);
    chk("lim0_up_wrap", wr, 1'b1);
    step();
    chk("lim0_up_wrap2", wr, 1'b1);
    ctl = 1'b0;
    step();
    chk("lim0_dn_count", cnt, 8'h00);
    chk("lim0_dn_wrap", wr, 1'b1);
    ctl = 1'b1; #1;
    chk("lim0_term_up", term, 1'b1);

    // reset during a wrap edge
    en = 1'b0; ld = 1'b1; lv = 8'h59; lim = 8'h59;
    step();
    chk("ld59", cnt, 8'h59);
    chk("term_at_limit", term, 1'b1);
    ld = 1'b0; en = 1'b1; ctl = 1'b1; reset = 1'b1;
    step();
    chk("rst_wrap_count", cnt, 8'h00);
    chk("rst_wrap_wrap", wr, 1'b0);
    reset = 1'b0;
    step();
    chk("post_rst_up", cnt, 8'h01);

    // hold, then load beats enable
    en = 1'b0;
    step();
    chk("hold_count", cnt, 8'h01);
    chk("hold_wrap", wr, 1'b0);
    en = 1'b1; ld = 1'b1; lv = 8'h07;
    step();
    chk("load_over_enable", cnt, 8'h07);
    ld = 1'b0; en = 1'b0;

    // four-digit triple carry / borrow
    ld4 = 1'b1; lv4 = 16'h0999;
    step();
    chk("d4_ld", cnt4, 16'h0999);
    ld4 = 1'b0; en4 = 1'b1; ctl4 = 1'b1;
    step();
    chk("d4_carry", cnt4, 16'h1000);
    ctl4 = 1'b0;
    step();
    chk("d4_borrow", cnt4, 16'h0999);
    chk("d4_wrap", wr4, 1'b0);

    // random sweep: counts stay legal BCD
    for (int c = 0; c < 300; c++) begin
      reset = ($urandom_range(0, 19) == 0);
      en  = $urandom_range(0, 1); ctl = $urandom_range(0, 1); ld = ($urandom_range(0, 5) == 0);
      lv  = 8'($urandom_range(0, 255));
      lim = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : bcd2($urandom_range(0, 99));
      en4 = $urandom_range(0, 1); ctl4 = $urandom_range(0, 1); ld4 = ($urandom_range(0, 5) == 0);
      lv4 = 16'($urandom_range(0, 65535));
      lim4 = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 65535))
                                         : {bcd2($urandom_range(0, 99)), bcd2($urandom_range(0, 99))};
      step();
      chk("rand_bcd2", all_bcd({8'h00, cnt}), 1'b1);
      chk("rand_bcd4", all_bcd(cnt4), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
